led_controller: RTL
===================

# led_controller

Memory-mapped LED controller that sits between the CPU data bus and the 24 board LEDs. It holds a pattern and a mode, and sequences the LEDs autonomously: static, blink, rotate-left or rotate-right. A programmable period counter sets the step rate, so software configures the block once instead of rewriting the LEDs every cycle.

## Interface
- BASE_ADDR, 32'hFFFF_F000: byte address of register 0. The block owns BASE_ADDR..BASE_ADDR+0xF.
- CNT_W, 32: width of the period and tick counters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  bus write strobe, sampled on clk rising edge
- addr  in  32  bus byte address; only addr[3:2] is decoded inside the window, and addr[1:0] is ignored
- wdata  in  32  bus write data
- rdata  out  32  combinational read data for addr; 0 outside the window
- led  out  24  registered LED drive

## Operation
- Registers, by offset:
  - 0x0 DATA: pattern[23:0], read/write; upper bits read 0.
  - 0x4 CTRL: [1:0] mode (0 static, 1 blink, 2 rotate-left, 3 rotate-right) and [2] enable; read/write.
  - 0x8 PERIOD: clk cycles per step, read/write. A value of 0 behaves as 1.
  - 0xC STATUS: read-only. [15:0] step count, [17:16] mode, [18] blink phase, [19] running (enable && mode!=0). Writes to it are ignored.
- A write is accepted when we=1 and addr is inside the window. Writes outside the window are ignored.
- Internal state:
  - work[23:0]: the working pattern.
  - phase: blink on/off.
  - tick: cycle counter.
  - steps[15:0]: step counter.
- FSM states:
  - OFF: enable=0. led=0, tick=0, no steps.
  - STATIC: mode 0. led=DATA, tick=0.
  - BLINK: mode 1. On each step phase toggles. led=DATA when phase=1, 0 when phase=0.
  - ROTATE: mode 2/3. On each step work rotates by 1 bit (left: work<={work[22:0],work[23]}; right: the mirror). led=work.
- The state is decoded directly from CTRL. A CTRL write moves to the new state on the next edge.
- Step event: fires in BLINK/ROTATE when tick == max(PERIOD,1)-1. On a step, tick<=0 and steps<=steps+1, wrapping 0xFFFF->0. Otherwise tick<=tick+1.
- Write side effects:
  - Any accepted write to DATA, CTRL or PERIOD restarts sequencing: tick<=0, phase<=1, work<=new DATA (or current DATA).
  - A CTRL write also clears steps.
- Simultaneous write and step in the same cycle: the write wins and the step is dropped (no toggle, rotate or count).
- Changing PERIOD mid-run takes effect immediately through the restart.

## Timing
- Reset values:
  - DATA=0, CTRL=3'b100 (enabled static), PERIOD=0.
  - work=0, phase=1, tick=0, steps=0.
  - led=0.
  - rdata follows these values.
- Reset is asynchronous. Asserting rst mid-run clears everything immediately. The first step after release comes PERIOD cycles after the first edge.
- Write latency: a write sampled at edge N is visible on led after edge N, and on rdata combinationally after edge N.
- BLINK with PERIOD=P, configured at edge N:
  - led=DATA over edges N..N+P-1.
  - led=0 from edge N+P.
  - Toggles every P cycles.
- ROTATE: first shift appears on led after edge N+P, then one shift every P cycles.
- PERIOD=0 or 1: a step fires every cycle.
- No bus stall: every write completes in a single cycle.

## Test plan
- Reset, then write DATA=0x00A5A5 at offset 0 -> led=0x00A5A5 the cycle after; rdata@0x0=0x00A5A5; rdata@0xC=0x0004_0000|bit18 per reset phase (mode 0, running=0).
- CTRL=0x5 (blink), PERIOD=4, DATA=0xFFFFFF -> led alternates 0xFFFFFF for 4 cycles and 0 for 4 cycles; STATUS[15:0] reaches 8 after 32 cycles.
- DATA=0x000001, PERIOD=1, CTRL=0x6 (rotate-left) -> led=0x000002, 0x000004, ... 0x800000, then 0x000001 on the 24th step (wrap). Same with CTRL=0x7: 0x800000 after step 1.
- Rotate running with PERIOD=3; issue a DATA write in the exact cycle a step is due -> no shift that cycle, led=new DATA, next shift exactly 3 cycles later.
- Assert rst for 1 ns between edges during blink -> led=0 and all registers at reset values immediately; write at addr BASE_ADDR+0x10 -> no register changes and rdata=0.
- CTRL=0x2 (enable=0) -> led=0 and STATUS[19]=0. Then CTRL=0x6 -> rotation starts, and STATUS steps[15:0] wraps 0xFFFF->0 after 65536 steps with PERIOD=1.

Source files
------------

// File: rtl/led_controller.sv
// led_controller: memory-mapped controller for 24 board LEDs.
// It holds a pattern, a mode and a step period. It sequences the LEDs
// autonomously: static, blink, rotate-left or rotate-right.
`timescale 1ns/1ps
module led_controller #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [23:0] led
);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_STATIC = 2'd1,
    S_BLINK  = 2'd2,
    S_ROTATE = 2'd3
  } state_t;

  // Register offsets, as seen on addr[3:2].
  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_CTRL   = 2'd1;
  localparam logic [1:0] OFS_PERIOD = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  // Architectural registers.
  logic [23:0]      data_q,   data_d;
  logic [2:0]       ctrl_q,   ctrl_d;
  logic [CNT_W-1:0] period_q, period_d;

  // Sequencing state.
  logic [23:0]      work_q,   work_d;
  logic             phase_q,  phase_d;
  logic [CNT_W-1:0] tick_q,   tick_d;
  logic [15:0]      steps_q,  steps_d;
  logic [23:0]      led_q,    led_d;

  state_t           state;
  logic             in_win;
  logic             wr_acc;
  logic             restart;
  logic             step_due;
  logic [CNT_W-1:0] last_tick;
  logic             unused_addr_bits;

  // The state is a pure decode of CTRL: enable gates everything, mode picks the sequencer.
  function automatic state_t decode_state(input logic [2:0] ctrl);
    if (!ctrl[2])              return S_OFF;
    else if (ctrl[1:0] == 2'd0) return S_STATIC;
    else if (ctrl[1:0] == 2'd1) return S_BLINK;
    else                        return S_ROTATE;
  endfunction

  // LED drive for a given set of next-state values, so writes show on led right after their edge.
  function automatic logic [23:0] led_drive(input logic [2:0] ctrl, input logic [23:0] data,
                                            input logic [23:0] work, input logic phase);
    case (decode_state(ctrl))
      S_STATIC: return data;
      S_BLINK:  return phase ? data : 24'h0;
      S_ROTATE: return work;
      default:  return 24'h0;
    endcase
  endfunction

  // The low two address bits only select bytes within a word and carry no meaning here.
  assign unused_addr_bits = ^addr[1:0];

  assign state     = decode_state(ctrl_q);
  assign in_win    = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_acc    = we && in_win;
  assign restart   = wr_acc && (addr[3:2] != OFS_STATUS);
  // A PERIOD of 0 behaves as 1, so the terminal tick is 0 in both cases.
  assign last_tick = (period_q == '0) ? '0 : period_q - 1'b1;
  assign step_due  = ((state == S_BLINK) || (state == S_ROTATE)) && (tick_q == last_tick);
  assign led       = led_q;

  // Combinational read mux; anything outside the 16-byte window reads as zero.
  always_comb begin
    rdata = 32'h0;
    if (in_win) begin
      case (addr[3:2])
        OFS_DATA:   rdata = {8'h0, data_q};
        OFS_CTRL:   rdata = {29'h0, ctrl_q};
        OFS_PERIOD: rdata = 32'(period_q);
        default:    rdata = {12'h0, (ctrl_q[2] && (ctrl_q[1:0] != 2'd0)), phase_q,
                             ctrl_q[1:0], steps_q};
      endcase
    end
  end

  // Next-state logic: bus writes first; a restarting write suppresses any step due that cycle.
  always_comb begin
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    work_d   = work_q;
    phase_d  = phase_q;
    tick_d   = tick_q;
    steps_d  = steps_q;

    if (wr_acc) begin
      case (addr[3:2])
        OFS_DATA:   data_d   = wdata[23:0];
        OFS_CTRL:   ctrl_d   = wdata[2:0];
        OFS_PERIOD: period_d = wdata[CNT_W-1:0];
        default:    ;
      endcase
    end

    if (restart) begin
      tick_d  = '0;
      phase_d = 1'b1;
      work_d  = data_d;
      if (addr[3:2] == OFS_CTRL) steps_d = 16'h0;
    end else begin
      case (state)
        S_BLINK, S_ROTATE: begin
          if (step_due) begin
            tick_d  = '0;
            steps_d = steps_q + 16'h1;
            if (state == S_BLINK) begin
              phase_d = ~phase_q;
            end else if (ctrl_q[1:0] == 2'd2) begin
              work_d = {work_q[22:0], work_q[23]};
            end else begin
              work_d = {work_q[0], work_q[23:1]};
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: tick_d = '0;
      endcase
    end

    led_d = led_drive(ctrl_d, data_d, work_d, phase_d);
  end

  // State registers with asynchronous reset; reset leaves the block enabled in static mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= 24'h0;
      ctrl_q   <= 3'b100;
      period_q <= '0;
      work_q   <= 24'h0;
      phase_q  <= 1'b1;
      tick_q   <= '0;
      steps_q  <= 16'h0;
      led_q    <= 24'h0;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      work_q   <= work_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      steps_q  <= steps_d;
      led_q    <= led_d;
    end
  end

endmodule
